// File: rtl/seq_010110_detector.sv
// rtl/seq_010110_detector.sv - non-overlapping 0-1-0-1-1-0 serial pattern detector
module seq_010110_detector #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   din,
    input  logic                   din_valid,
    input  logic                   count_clr,
    output logic                   detected,
    output logic [2:0]             state,
    output logic [COUNT_WIDTH-1:0] match_count
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   detected_q, detected_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   match;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S0;
            detected_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            detected_q <= detected_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match   = 1'b0;
        // Mismatches fall back to the longest suffix that is still a prefix.
        case (state_q)
            S0: if (din_valid) state_d = din ? S0 : S1;
            S1: if (din_valid) state_d = din ? S2 : S1;
            S2: if (din_valid) state_d = din ? S0 : S3;
            S3: if (din_valid) state_d = din ? S4 : S1;
            S4: if (din_valid) state_d = din ? S5 : S3;
            S5: if (din_valid) begin
                state_d = S0;
                match   = ~din;
            end
            default: state_d = S0;
        endcase

        detected_d = match;

        count_d = count_q;
        if (count_clr) begin
            count_d = '0;
        end else if (match && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    assign detected    = detected_q;
    assign state       = state_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_010110_detector.sv
// tb/tb_seq_010110_detector.sv - randomized and directed checks against a bit-history model
module tb_seq_010110_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       count_clr;
    logic       det8, det2;
    logic [2:0] st8, st2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    // Model: valid bits since the last reset or match; state is the longest suffix matching a pattern prefix.
    int pat [6] = '{0, 1, 0, 1, 1, 0};
    int hist [$];
    int exp_det = 0;
    int exp_cnt8 = 0;
    int exp_cnt2 = 0;

    always #5 clk = ~clk;

    seq_010110_detector #(.COUNT_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .count_clr(count_clr), .detected(det8), .state(st8), .match_count(cnt8)
    );

    seq_010110_detector #(.COUNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .count_clr(count_clr), .detected(det2), .state(st2), .match_count(cnt2)
    );

    function automatic int suffix_len();
        int n;
        bit ok;
        n = hist.size();
        for (int k = 6; k > 0; k--) begin
            if (k <= n) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (hist[n - k + j] != pat[j]) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst_n, input bit v, input bit d, input bit clr);
        bit m;
        reset     = rst_n;
        din_valid = v;
        din       = d;
        count_clr = clr;
        @(posedge clk);
        m = 1'b0;
        if (!rst_n) begin
            hist.delete();
            exp_det  = 0;
            exp_cnt8 = 0;
            exp_cnt2 = 0;
        end else begin
            if (v) begin
                hist.push_back(int'(d));
                if (hist.size() > 6) void'(hist.pop_front());
                if (suffix_len() == 6) begin
                    m = 1'b1;
                    hist.delete();
                end
            end
            exp_det = int'(m);
            if (clr) begin
                exp_cnt8 = 0;
                exp_cnt2 = 0;
            end else if (m) begin
                if (exp_cnt8 < 255) exp_cnt8++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
        #1;
        chk("state8", int'(st8), suffix_len());
        chk("state2", int'(st2), suffix_len());
        chk("detected8", int'(det8), exp_det);
        chk("detected2", int'(det2), exp_det);
        chk("count8", int'(cnt8), exp_cnt8);
        chk("count2", int'(cnt2), exp_cnt2);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input int bubbles);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, 1'b1, bits[i], 1'b0);
            for (int b = 0; b < bubbles; b++) step(1'b1, 1'b0, b[0], 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0; din = 1'b0; din_valid = 1'b0; count_clr = 1'b0;
        #1;
        // Basic match after reset
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        send_bits(16'b010110, 6, 0);
        chk("basic_pulse", int'(det8), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("basic_pulse_end", int'(det8), 0);

        // Non-overlap
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(16'b01011010110, 11, 0);
        chk("nonoverlap_state", int'(st8), 1);
        chk("nonoverlap_count", int'(cnt8), 1);

        // Fallback
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(16'b0101010110, 10, 0);
        chk("fallback_count", int'(cnt8), 1);

        // Bubbles with din toggling
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(16'b010110, 6, 3);

        // Saturation on the narrow counter, then clear on a matching edge
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 5; p++) send_bits(16'b010110, 6, 0);
        chk("sat_count2", int'(cnt2), 3);
        chk("sat_count8", int'(cnt8), 5);
        send_bits(16'b01011, 5, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_wins_count", int'(cnt2), 0);
        chk("clr_wins_pulse", int'(det2), 1);

        // Reset mid-sequence
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(16'b01011, 5, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midreset_state", int'(st8), 1);
        chk("midreset_det", int'(det8), 0);

        // Random traffic biased toward the pattern
        for (int i = 0; i < 3000; i++) begin
            bit v, d, c, r;
            v = ($urandom_range(0, 3) != 0);
            d = (suffix_len() < 6 && $urandom_range(0, 3) != 0) ? pat[suffix_len()][0] : $urandom_range(0, 1);
            c = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 199) != 0);
            step(r, v, d, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
